stream_mux: RTL and testbench

- Registered, handshaked successor to the combinational generic mux.
- Selects one of 2**SELECT_SIZE valid/ready input streams, either by an explicit port index or by round-robin arbitration.
- Drives a single registered output stream tagged with the source port index.
- Used between FPU operand/result producers and shared downstream consumers, such as a shared normaliser or writeback.

---
 rtl/stream_mux_if.sv | 41 ++++
 rtl/stream_mux.sv | 125 ++++++++++++
 tb/tb_stream_mux.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/stream_mux_if.sv
// Handshake bundle for stream_mux: N valid/ready input channels in, one tagged stream out.
// Defining STREAM_MUX_LAST_EN adds the in_last/out_last packet-framing signals.
interface stream_mux_if #(
  parameter int DATA_SIZE   = 32,
  parameter int SELECT_SIZE = 2
);
  localparam int PORT_COUNT = 1 << SELECT_SIZE;

  logic                   mode;
  logic [SELECT_SIZE-1:0] port;
  logic [PORT_COUNT-1:0]  in_valid;
  logic [DATA_SIZE-1:0]   in_data [PORT_COUNT];
  logic [PORT_COUNT-1:0]  in_ready;
  logic                   out_valid;
  logic [DATA_SIZE-1:0]   out_data;
  logic [SELECT_SIZE-1:0] out_port;
  logic                   out_ready;
`ifdef STREAM_MUX_LAST_EN
  logic [PORT_COUNT-1:0]  in_last;
  logic                   out_last;
`endif

  // The mux itself is the slave; producers and the consumer together form the master.
  modport slave (
    input  mode, port, in_valid, in_data, out_ready,
`ifdef STREAM_MUX_LAST_EN
    input  in_last,
    output out_last,
`endif
    output in_ready, out_valid, out_data, out_port
  );

  modport master (
    output mode, port, in_valid, in_data, out_ready,
`ifdef STREAM_MUX_LAST_EN
    output in_last,
    input  out_last,
`endif
    input  in_ready, out_valid, out_data, out_port
  );
endinterface

// File: rtl/stream_mux.sv
// Registered valid/ready stream mux: fixed-port or round-robin selection, one-deep output stage.
// Optional STREAM_MUX_LAST_EN holds the grant on one channel until its in_last beat is accepted.
module stream_mux #(
  parameter int DATA_SIZE   = 32,
  parameter int SELECT_SIZE = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  stream_mux_if.slave  bus
);
  localparam int PORT_COUNT = 1 << SELECT_SIZE;

  logic                   r_out_valid;
  logic [DATA_SIZE-1:0]   r_out_data;
  logic [SELECT_SIZE-1:0] r_out_port;
  logic [SELECT_SIZE-1:0] r_ptr;

  logic                   w_load;
  logic                   w_xfer;
  logic                   w_ptr_upd;
  logic                   w_grant_valid;
  logic [SELECT_SIZE-1:0] w_grant;
  logic                   w_rr_found;
  logic [SELECT_SIZE-1:0] w_rr_grant;
  logic [SELECT_SIZE-1:0] w_idx;

`ifdef STREAM_MUX_LAST_EN
  logic                   r_out_last;
  logic                   r_locked;
  logic                   r_lock_rr;
  logic [SELECT_SIZE-1:0] r_lock_port;
`endif

  assign w_load = !r_out_valid || bus.out_ready;

  // Scan from the highest offset down so the channel nearest ptr+1 wins the final assignment.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    w_rr_found = 1'b0;
    w_rr_grant = '0;
    w_idx      = '0;
    for (int i = PORT_COUNT - 1; i >= 0; i--) begin
      w_idx = r_ptr + SELECT_SIZE'(i + 1);
      if (bus.in_valid[w_idx]) begin
        w_rr_found = 1'b1;
        w_rr_grant = w_idx;
      end
    end
  end

  always_comb begin
    w_grant       = w_rr_grant;
    w_grant_valid = w_rr_found;
`ifdef STREAM_MUX_LAST_EN
    if (r_locked) begin
      w_grant       = r_lock_port;
      w_grant_valid = 1'b1;
    end else if (!bus.mode) begin
      w_grant       = bus.port;
      w_grant_valid = 1'b1;
    end
`else
    if (!bus.mode) begin
      w_grant       = bus.port;
      w_grant_valid = 1'b1;
    end
`endif
  end

  // Ready is gated by rst_n directly so producers see no acceptance during a reset cycle.
  always_comb begin
    bus.in_ready = '0;
    if (rst_n && w_grant_valid && w_load) bus.in_ready[w_grant] = 1'b1;
  end

  assign w_xfer = rst_n && w_grant_valid && w_load && bus.in_valid[w_grant];

`ifdef STREAM_MUX_LAST_EN
  // A locked packet moves ptr only when its closing beat lands, and only if it was arbitrated.
  assign w_ptr_upd = w_xfer && bus.in_last[w_grant] && (r_locked ? r_lock_rr : bus.mode);
`else
  assign w_ptr_upd = w_xfer && bus.mode;
`endif

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_port  <= '0;
      r_ptr       <= '1;
    end else begin
      if (w_load) r_out_valid <= w_xfer;
      if (w_xfer) begin
        r_out_data <= bus.in_data[w_grant];
        r_out_port <= w_grant;
      end
      if (w_ptr_upd) r_ptr <= w_grant;
    end
  end

`ifdef STREAM_MUX_LAST_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_last  <= 1'b0;
      r_locked    <= 1'b0;
      r_lock_rr   <= 1'b0;
      r_lock_port <= '0;
    end else if (w_xfer) begin
      r_out_last <= bus.in_last[w_grant];
      r_locked   <= !bus.in_last[w_grant];
      if (!r_locked) begin
        r_lock_port <= w_grant;
        r_lock_rr   <= bus.mode;
      end
    end
  end

  assign bus.out_last = r_out_last;
`endif

  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_port  = r_out_port;
endmodule

// File: tb/tb_stream_mux.sv
// Self-checking bench for stream_mux: directed scenarios plus randomized traffic against a
// transaction-level model (output slot, round-robin pointer as an integer, modulo search).
module tb_stream_mux;
  localparam int DW = 32;
  localparam int SW = 2;
  localparam int PC = 1 << SW;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  int          m_ptr;
  bit          m_valid;
  logic [31:0] m_data;
  int          m_port;

  stream_mux_if #(.DATA_SIZE(DW), .SELECT_SIZE(SW)) bus ();
  stream_mux #(.DATA_SIZE(DW), .SELECT_SIZE(SW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: predict ready from the model, cross the edge, then compare the output register.
  task automatic step(input string tag);
    bit          load, found, xfer;
    int          g, c;
    logic [3:0]  exp_ready;
    logic [31:0] d;
    #1;
    load  = !m_valid || bus.out_ready;
    found = 0;
    g     = 0;
    if (bus.mode == 1'b0) begin
      g     = int'(bus.port);
      found = 1;
    end else begin
      for (int k = 1; k <= PC; k++) begin
        c = (m_ptr + k) % PC;
        if (!found && bus.in_valid[c]) begin
          g     = c;
          found = 1;
        end
      end
    end
    exp_ready = (rst_n && found && load) ? 4'(1 << g) : 4'd0;
    check({tag, "/in_ready"}, 64'(bus.in_ready), 64'(exp_ready));
    xfer = rst_n && found && load && bus.in_valid[g];
    d    = bus.in_data[g];
    @(posedge clk);
    #1;
    if (!rst_n) begin
      m_valid = 0;
      m_data  = '0;
      m_port  = 0;
      m_ptr   = PC - 1;
    end else begin
      if (load) m_valid = xfer;
      if (xfer) begin
        m_data = d;
        m_port = g;
        if (bus.mode) m_ptr = g;
      end
    end
    check({tag, "/out_valid"}, 64'(bus.out_valid), 64'(m_valid));
    check({tag, "/out_data"},  64'(bus.out_data),  64'(m_data));
    check({tag, "/out_port"},  64'(bus.out_port),  64'(m_port));
  endtask

  initial begin
    m_ptr = PC - 1; m_valid = 0; m_data = '0; m_port = 0;
    rst_n         = 1'b0;
    bus.mode      = 1'b1;
    bus.port      = '0;
    bus.in_valid  = 4'b1111;
    bus.out_ready = 1'b1;
    for (int i = 0; i < PC; i++) bus.in_data[i] = 32'h1000_0000 + 32'(i);
`ifdef STREAM_MUX_LAST_EN
    bus.in_last = '1;
`endif

    // Reset held two cycles with every channel requesting.
    step("reset0");
    step("reset1");
    check("reset/out_valid", 64'(bus.out_valid), 64'd0);
    check("reset/out_port",  64'(bus.out_port),  64'd0);

    // Round-robin fairness: one beat per cycle in order 0,1,2,3,0,1,2,3.
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step("rr_fair");
      check("rr_fair/seq", 64'(bus.out_port), 64'(i % PC));
    end

    // Fixed select of channel 2.
    bus.mode       = 1'b0;
    bus.port       = 2'd2;
    bus.in_valid   = 4'b0100;
    bus.in_data[2] = 32'hDEAD_BEEF;
    #1 check("fixed/in_ready", 64'(bus.in_ready), 64'b0100);
    step("fixed");
    check("fixed/data", 64'(bus.out_data), 64'hDEAD_BEEF);

    // Backpressure: outputs frozen and no channel ready for three cycles.
    bus.mode      = 1'b1;
    bus.in_valid  = 4'b1111;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step("bp_hold");
      check("bp_hold/data", 64'(bus.out_data), 64'hDEAD_BEEF);
    end
    bus.out_ready = 1'b1;
    step("bp_release");

    // Sparse request set with wrap from ptr=3.
    bus.in_valid = 4'b1000;
    step("sparse_set");
    bus.in_valid = 4'b0101;
    step("sparse0");
    check("sparse0/port", 64'(bus.out_port), 64'd0);
    step("sparse1");
    check("sparse1/port", 64'(bus.out_port), 64'd2);
    step("sparse2");
    check("sparse2/port", 64'(bus.out_port), 64'd0);
    bus.in_valid = 4'b0000;
    step("drain");
    check("drain/out_valid", 64'(bus.out_valid), 64'd0);

    // Randomized traffic including mode flips, port changes, stalls and occasional reset.
    for (int n = 0; n < 400; n++) begin
      rst_n         = ($urandom_range(0, 39) == 0) ? 1'b0 : 1'b1;
      bus.mode      = 1'($urandom_range(0, 1));
      bus.port      = 2'($urandom_range(0, PC - 1));
      bus.in_valid  = 4'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < PC; i++) bus.in_data[i] = $urandom;
      step("random");
    end

`ifdef STREAM_MUX_LAST_EN
    // Packet lock: channel 1 sends three beats; mode/port changes mid-packet are ignored.
    rst_n = 1'b0;
    bus.out_ready = 1'b1;
    step("pkt_reset");
    rst_n        = 1'b1;
    bus.mode     = 1'b1;
    bus.in_valid = 4'b0110;
    bus.in_last  = 4'b1101;
    #1 check("pkt0/in_ready", 64'(bus.in_ready), 64'b0010);
    @(posedge clk); #1;
    check("pkt0/port", 64'(bus.out_port), 64'd1);
    check("pkt0/last", 64'(bus.out_last), 64'd0);
    bus.mode = 1'b0;
    bus.port = 2'd3;
    #1 check("pkt1/in_ready", 64'(bus.in_ready), 64'b0010);
    @(posedge clk); #1;
    check("pkt1/port", 64'(bus.out_port), 64'd1);
    check("pkt1/last", 64'(bus.out_last), 64'd0);
    bus.in_last = 4'b1111;
    #1 check("pkt2/in_ready", 64'(bus.in_ready), 64'b0010);
    @(posedge clk); #1;
    check("pkt2/port", 64'(bus.out_port), 64'd1);
    check("pkt2/last", 64'(bus.out_last), 64'd1);
    bus.mode = 1'b1;
    #1 check("pkt3/in_ready", 64'(bus.in_ready), 64'b0100);
    @(posedge clk); #1;
    check("pkt3/port", 64'(bus.out_port), 64'd2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
